// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter and pointer/status controller for a shared FIFO memory.
// Optional stall counter is built only when FIFO_WR_STATS_EN is defined.
module fifo_wr_arbiter #(
  parameter int DATA_SIZE    = 32,
  parameter int ADDR_SIZE    = 5,
  parameter int NUM_REQ      = 4,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [2:0]                   grant_id,
  input  logic                         rd_en,
  output logic [DATA_SIZE-1:0]         rd_data,
  output logic                         empty,
  output logic                         full,
  output logic                         almost_full,
  output logic [ADDR_SIZE:0]           level,
  output logic [DATA_SIZE-1:0]         mem_wdata,
  output logic [ADDR_SIZE-1:0]         mem_waddr,
  output logic [ADDR_SIZE-1:0]         mem_raddr,
  output logic                         mem_wclk_en,
  output logic                         mem_wfull,
  input  logic [DATA_SIZE-1:0]         mem_rdata,
  output logic [15:0]                  stall_cnt
);

  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam int PW    = ADDR_SIZE + 1;

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
  logic [2:0]    rr_ptr_q, rr_ptr_d;
  logic          empty_q, empty_d, full_q, full_d, afull_q, afull_d;
  logic [2:0]    winner;
  logic          any_valid, wr_fire, rd_fire;

  // Search starts at rr_ptr and wraps; the first valid requester at the lowest offset wins.
  always_comb begin
    // NOTE: every combinational output gets a default before the loop so no latch is inferred.
    winner    = '0;
    any_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int idx;
      idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        winner    = 3'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_ready[i] = any_valid && !full_q && !rst && (winner == 3'(i));
  end

  assign grant_id    = winner;
  assign wr_fire     = |(req_valid & req_ready);
  assign rd_fire     = rd_en && !empty_q;
  assign mem_wclk_en = wr_fire;
  assign mem_wdata   = req_data[int'(winner)*DATA_SIZE +: DATA_SIZE];
  assign mem_waddr   = wptr_q[ADDR_SIZE-1:0];
  assign mem_raddr   = rptr_q[ADDR_SIZE-1:0];
  assign rd_data     = mem_rdata;

  // Status is computed from next-state pointers so the flags register together with them.
  always_comb begin
    wptr_d   = wr_fire ? wptr_q + PW'(1) : wptr_q;
    rptr_d   = rd_fire ? rptr_q + PW'(1) : rptr_q;
    rr_ptr_d = rr_ptr_q;
    if (wr_fire)
      rr_ptr_d = (winner == 3'(NUM_REQ-1)) ? 3'd0 : winner + 3'd1;
    level_d  = wptr_d - rptr_d;
    empty_d  = (level_d == '0);
    full_d   = (level_d == PW'(DEPTH));
    afull_d  = (level_d >= PW'(DEPTH - AFULL_MARGIN));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      rr_ptr_q <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all of them see pre-edge values.
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      rr_ptr_q <= rr_ptr_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
    end
  end

  assign level       = level_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign mem_wfull   = full_q;
  assign almost_full = afull_q;

`ifdef FIFO_WR_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Counts cycles where a requester is turned away because the FIFO is full; saturates.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (full_q && |req_valid && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
